// File: rtl/spam_console_uart_pkg.sv
// Shared types and constants for the SPAM console UART bridge.
package spam_console_uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/spam_console_uart_if.sv
// Console-side sys_* port: the console is the master, the UART bridge the slave.
interface spam_console_uart_if;
   logic [8:0] sys_odata;
   logic [8:0] sys_idata;
   logic       sys_tookdata;

   modport master (output sys_odata, output sys_tookdata, input sys_idata);
   modport slave  (input sys_odata, input sys_tookdata, output sys_idata);
endinterface

// File: rtl/spam_console_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push on full is accepted only alongside a pop.
module spam_console_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      head     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/spam_console_uart.sv
// SPAM console bridge: buffered 8N1 transmitter, synchronised receiver with FIFO,
// and the console {present, byte} port with its one-cycle-late take acknowledge.
//
// state   | TX meaning                    | RX meaning
// IDLE    | line high, waiting for data   | waiting for falling edge
// START   | driving start bit (0)         | half-bit wait, glitch recheck
// DATA    | shifting 8 bits LSB first     | sampling 8 bits mid-bit
// STOP    | driving stop bit (1)          | waiting for stop sample
module spam_console_uart
   import spam_console_uart_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int BAUD     = 115200,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_b,
   spam_console_uart_if.slave sys,
   output logic               uart_tx,
   input  logic               uart_rx,
   output logic               tx_overflow,
   output logic               rx_overflow,
   output logic               rx_frame_err
);
   localparam int             DIV       = CLK_HZ / BAUD;
   localparam int             CW        = $clog2(DIV);
   localparam logic [CW-1:0]  BIT_LOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0]  HALF_LOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0]  ONE       = CW'(1);
   localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

   if (DIV < 4) begin : g_bad_div
      $error("spam_console_uart: CLK_HZ/BAUD must be at least 4");
   end
   if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_txd
      $error("spam_console_uart: TX_DEPTH must be a power of two >= 2");
   end
   if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rxd
      $error("spam_console_uart: RX_DEPTH must be a power of two >= 2");
   end

   uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic          tx_line_q, tx_line_d;
   logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic          rx_push_q, rx_push_d;
   logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_ferr_q, rx_ferr_d;
   logic          pres_q, pres_d;

   logic          tx_full, tx_empty, tx_pop, tx_strobe;
   logic [7:0]    tx_head;
   logic          rx_full, rx_empty, rx_pop;
   logic [7:0]    rx_head;
   logic [8:0]    idata;

   spam_console_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_b(rst_b), .push(tx_strobe), .din(sys.sys_odata[7:0]),
      .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
   );

   spam_console_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_b(rst_b), .push(rx_push_q), .din(rx_shift_q),
      .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
   );

   // Masking during tookdata hides the head that is being consumed this cycle.
   always_comb begin
      tx_strobe = sys.sys_odata[8];
      idata     = {~rx_empty & ~sys.sys_tookdata,
                   (rx_empty | sys.sys_tookdata) ? 8'h00 : rx_head};
      pres_d    = idata[8];
      rx_pop    = sys.sys_tookdata & pres_q;
      tx_ovf_d  = tx_ovf_q | (tx_strobe & tx_full & ~tx_pop);
      rx_ovf_d  = rx_ovf_q | (rx_push_q & rx_full & ~rx_pop);
   end

   assign sys.sys_idata = idata;
   assign uart_tx       = tx_line_q;
   assign tx_overflow   = tx_ovf_q;
   assign rx_overflow   = rx_ovf_q;
   assign rx_frame_err  = rx_ferr_q;

   // STOP hands straight to the next queued byte so frames run back to back.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_line_d  = tx_line_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = BIT_LOAD;
               tx_bit_d   = 3'd0;
               tx_line_d  = tx_shift_q[0];
            end else tx_cnt_d = tx_cnt_q - ONE;
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = BIT_LOAD;
               if (tx_bit_q == LAST_BIT) begin
                  tx_state_d = S_STOP;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_line_d  = tx_shift_q[1];
               end
            end else tx_cnt_d = tx_cnt_q - ONE;
         end
         default: begin
            if (tx_state_q == S_STOP && tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - ONE;
            end else if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_cnt_d   = BIT_LOAD;
               tx_state_d = S_START;
               tx_line_d  = 1'b0;
            end else begin
               tx_state_d = S_IDLE;
               tx_line_d  = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      rx_meta_d  = uart_rx;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_bit_d   = rx_bit_q;
      rx_push_d  = 1'b0;
      rx_ferr_d  = rx_ferr_q;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q & ~rx_sync_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = HALF_LOAD;
            end
         end
         S_START: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
               rx_cnt_d   = BIT_LOAD;
               rx_bit_d   = 3'd0;
            end else rx_cnt_d = rx_cnt_q - ONE;
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_cnt_d   = BIT_LOAD;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == LAST_BIT) rx_state_d = S_STOP;
               else rx_bit_d = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - ONE;
         end
         default: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = S_IDLE;
               rx_push_d  = rx_sync_q;
               rx_ferr_d  = rx_ferr_q | ~rx_sync_q;
            end else rx_cnt_d = rx_cnt_q - ONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_line_q  <= 1'b1;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_shift_q <= '0;
         rx_bit_q   <= '0;
         rx_push_q  <= 1'b0;
         tx_ovf_q   <= 1'b0;
         rx_ovf_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         pres_q     <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx_line_q  <= tx_line_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_push_q  <= rx_push_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_ovf_q   <= rx_ovf_d;
         rx_ferr_q  <= rx_ferr_d;
         pres_q     <= pres_d;
      end
   end

endmodule

// File: tb/tb_spam_console_uart.sv
// Bench for spam_console_uart: queue-based line/console model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_spam_console_uart;
   import spam_console_uart_pkg::*;

   localparam int DIV       = 10;
   localparam int TXD       = 16;
   localparam int RXD       = 16;
   localparam int FRAME_CYC = FRAME_BITS * DIV;
   localparam int STOP_LAT  = 3 + DIV / 2 + 9 * DIV;

   typedef struct {
      int         t;
      logic [7:0] b;
      bit         ok;
   } rx_ev_t;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_tx, tx_overflow, rx_overflow, rx_frame_err;

   spam_console_uart_if sif ();

   spam_console_uart #(
      .CLK_HZ(50000000), .BAUD(5000000), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
   ) dut (
      .clk(clk), .rst_b(rst_b), .sys(sif), .uart_tx(uart_tx), .uart_rx(uart_rx),
      .tx_overflow(tx_overflow), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [7:0] txq[$];
   logic [7:0] sent[$];
   logic [7:0] rxq[$];
   rx_ev_t     rx_ev[$];
   int         tx_pos = -1;
   logic [7:0] tx_cur = 8'h00;
   bit         m_txovf = 1'b0, m_rxovf = 1'b0, m_ferr = 1'b0;
   bit         m_pres_old = 1'b0, m_pres_cur = 1'b0;
   logic [8:0] exp_id;

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expired(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic exp_line();
      int i;
      if (tx_pos < 0) return 1'b1;
      i = tx_pos / DIV;
      if (i == 0) return 1'b0;
      if (i == FRAME_BITS - 1) return 1'b1;
      return tx_cur[i-1];
   endfunction

   // Model: a frame occupies FRAME_CYC cycles from the edge it is popped; queues hold bytes.
   always @(posedge clk) begin
      cyc++;
      if (!rst_b) begin
         txq.delete();
         rxq.delete();
         rx_ev.delete();
         tx_pos  = -1;
         m_txovf = 1'b0;
         m_rxovf = 1'b0;
         m_ferr  = 1'b0;
      end else begin
         if (tx_pos >= 0) begin
            tx_pos++;
            if (tx_pos == FRAME_CYC) tx_pos = -1;
         end
         if (tx_pos < 0 && txq.size() > 0) begin
            tx_cur = txq.pop_front();
            sent.push_back(tx_cur);
            tx_pos = 0;
         end
         if (sif.sys_odata[8]) begin
            if (txq.size() < TXD) txq.push_back(sif.sys_odata[7:0]);
            else m_txovf = 1'b1;
         end
         if (sif.sys_tookdata && m_pres_old && rxq.size() > 0) void'(rxq.pop_front());
         if (rx_ev.size() > 0) begin
            if (!rx_ev[0].ok && cyc == rx_ev[0].t) begin
               m_ferr = 1'b1;
               void'(rx_ev.pop_front());
            end else if (rx_ev[0].ok && cyc == rx_ev[0].t + 1) begin
               if (rxq.size() < RXD) rxq.push_back(rx_ev[0].b);
               else m_rxovf = 1'b1;
               void'(rx_ev.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_b) begin
         exp_id     = (rxq.size() > 0 && !sif.sys_tookdata) ? {1'b1, rxq[0]} : 9'h000;
         m_pres_old = m_pres_cur;
         m_pres_cur = exp_id[8];
         chk("uart_tx", {8'h00, uart_tx}, {8'h00, exp_line()});
         chk("sys_idata", sif.sys_idata, exp_id);
         chk("tx_overflow", {8'h00, tx_overflow}, {8'h00, m_txovf});
         chk("rx_overflow", {8'h00, rx_overflow}, {8'h00, m_rxovf});
         chk("rx_frame_err", {8'h00, rx_frame_err}, {8'h00, m_ferr});
      end else begin
         m_pres_old = 1'b0;
         m_pres_cur = 1'b0;
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit ok);
      rx_ev_t ev;
      ev.t  = cyc + STOP_LAT;
      ev.b  = b;
      ev.ok = ok;
      rx_ev.push_back(ev);
      uart_rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(DIV);
      end
      uart_rx = ok;
      tick(DIV);
      uart_rx = 1'b1;
      if (!ok) tick(DIV);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] pat;
      logic [7:0] ob[17];
      logic [7:0] rb;
      int         base, got, g;

      sif.sys_odata    = 9'h000;
      sif.sys_tookdata = 1'b0;
      tick(3);
      rst_b = 1'b1;
      chk("reset_tx", {8'h00, uart_tx}, 9'h001);
      chk("reset_idata", sif.sys_idata, 9'h000);
      chk("reset_flags", {6'h00, tx_overflow, rx_overflow, rx_frame_err}, 9'h000);
      tick(2);

      // TX single byte 0x41
      pat = 10'b10_1000_0010;
      sif.sys_odata = 9'h141;
      tick(1);
      sif.sys_odata = 9'h000;
      chk("tx_before_start", {8'h00, uart_tx}, 9'h001);
      tick(1);
      chk("tx_start_at_2", {8'h00, uart_tx}, 9'h000);
      tick(DIV / 2);
      for (int k = 0; k < FRAME_BITS; k++) begin
         chk("tx_single_bit", {8'h00, uart_tx}, {8'h00, pat[k]});
         tick(DIV);
      end

      // TX overflow: 20 back-to-back strobes
      base = sent.size();
      for (int i = 0; i < 20; i++) begin
         sif.sys_odata = {1'b1, 8'(i)};
         tick(1);
      end
      sif.sys_odata = 9'h000;
      tick(17 * FRAME_CYC + 10);
      chk("tx_ovf_flag", {8'h00, tx_overflow}, 9'h001);
      chk("tx_sent_count", 9'(sent.size() - base), 9'd17);
      chk("tx_first_sent", {1'b0, sent[base]}, 9'h000);
      chk("tx_last_sent", {1'b0, sent[sent.size()-1]}, 9'h010);

      // RX plus console handshake
      send_frame(8'h5A, 1'b1);
      send_frame(8'hA5, 1'b1);
      tick(2);
      chk("rx_head_5a", sif.sys_idata, 9'h15A);
      sif.sys_tookdata = 1'b1;
      #1 chk("rx_took_mask1", sif.sys_idata, 9'h000);
      tick(1);
      sif.sys_tookdata = 1'b0;
      #1 chk("rx_head_a5", sif.sys_idata, 9'h1A5);
      tick(1);
      sif.sys_tookdata = 1'b1;
      #1 chk("rx_took_mask2", sif.sys_idata, 9'h000);
      tick(1);
      sif.sys_tookdata = 1'b0;
      #1 chk("rx_drained", sif.sys_idata, 9'h000);
      tick(2);

      // RX glitch and framing error
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      tick(2 * DIV);
      chk("rx_glitch_none", sif.sys_idata, 9'h000);
      send_frame(8'hC3, 1'b0);
      tick(2);
      chk("rx_ferr_flag", {8'h00, rx_frame_err}, 9'h001);
      chk("rx_ferr_nopush", sif.sys_idata, 9'h000);

      // RX overflow: 17 frames, nothing consumed
      for (int k = 0; k < 17; k++) begin
         ob[k] = 8'($urandom);
         send_frame(ob[k], 1'b1);
      end
      tick(2);
      chk("rx_ovf_flag", {8'h00, rx_overflow}, 9'h001);
      got = 0;
      for (g = 0; g < 40 && sif.sys_idata[8]; g++) begin
         chk("rx_ovf_keep", sif.sys_idata, {1'b1, ob[(got < 17) ? got : 16]});
         got++;
         sif.sys_tookdata = 1'b1;
         tick(1);
         sif.sys_tookdata = 1'b0;
         tick(1);
      end
      chk("rx_ovf_count", 9'(got), 9'd16);

      // Randomised traffic on all three sides
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               tick($urandom_range(0, 120));
               sif.sys_odata = {1'b1, 8'($urandom)};
               tick(1);
               sif.sys_odata = 9'h000;
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               tick($urandom_range(0, 40));
               send_frame(8'($urandom), $urandom_range(0, 4) != 0);
            end
         end
         begin
            for (int i = 0; i < 1500; i++) begin
               sif.sys_tookdata = ($urandom_range(0, 2) == 0);
               tick(1);
            end
            sif.sys_tookdata = 1'b0;
         end
      join
      for (g = 0; g < 3000 && !(tx_pos < 0 && txq.size() == 0); g++) tick(1);
      if (!(tx_pos < 0 && txq.size() == 0)) expired("tx_drain");
      for (g = 0; g < 40 && sif.sys_idata[8]; g++) begin
         sif.sys_tookdata = 1'b1;
         tick(1);
         sif.sys_tookdata = 1'b0;
         tick(1);
      end
      tick(2);

      // Reset in the middle of a TX frame with a byte waiting in the RX FIFO
      send_frame(8'h77, 1'b1);
      tick(2);
      chk("pre_rst_idata", sif.sys_idata, 9'h177);
      sif.sys_odata = 9'h13C;
      tick(1);
      sif.sys_odata = 9'h000;
      tick(1 + 3 * DIV);
      chk("pre_rst_tx_busy", {8'h00, tx_pos >= 0}, 9'h001);
      #2 rst_b = 1'b0;
      #1;
      chk("rst_tx_high", {8'h00, uart_tx}, 9'h001);
      chk("rst_idata", sif.sys_idata, 9'h000);
      chk("rst_flags", {6'h00, tx_overflow, rx_overflow, rx_frame_err}, 9'h000);
      tick(2);
      rst_b = 1'b1;
      tick(2);
      sif.sys_odata = 9'h1A7;
      tick(1);
      sif.sys_odata = 9'h000;
      for (g = 0; g < 20 && uart_tx; g++) tick(1);
      if (uart_tx) expired("post_rst_start");
      tick(DIV / 2);
      rb = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick(DIV);
         rb[i] = uart_tx;
      end
      tick(DIV);
      chk("post_rst_stop", {8'h00, uart_tx}, 9'h001);
      chk("post_rst_byte", {1'b0, rb}, 9'h0A7);
      tick(DIV + 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
